// File: rtl/packet_arbiter_rr.sv
// Round-robin packet arbiter: locks one input port from its header beat through its TLAST beat.
// Optional performance counters are enabled by defining PACKET_ARBITER_PERF_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no grant held; searching for a header request after ptr_q
// ST_LOCKED | grant held on port idx_q until its TLAST beat transfers
module packet_arbiter_rr #(
   parameter int INPUT_NUMBER       = 5,
   parameter int INPUT_NUMBER_WIDTH = (INPUT_NUMBER > 2) ? $clog2(INPUT_NUMBER) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic [INPUT_NUMBER-1:0]       req_valid_i,
   input  logic [INPUT_NUMBER-1:0]       req_header_i,
   input  logic [INPUT_NUMBER-1:0]       req_last_i,
   input  logic                          out_ready_i,
   output logic [INPUT_NUMBER-1:0]       grant_o,
   output logic [INPUT_NUMBER_WIDTH-1:0] grant_idx_o,
   output logic                          grant_valid_o,
   output logic                          grant_vc_o,
   output logic                          proto_err_o,
   output logic [15:0]                   pkt_count_o,
   output logic [15:0]                   stall_count_o
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e                        state_q, state_d;
   logic [INPUT_NUMBER_WIDTH-1:0] ptr_q, ptr_d;
   logic [INPUT_NUMBER_WIDTH-1:0] idx_q, idx_d;
   logic                          vc_q, vc_d;
   logic                          err_q, err_d;

   logic                          sel_found;
   logic [INPUT_NUMBER_WIDTH-1:0] sel_idx;
   logic [INPUT_NUMBER_WIDTH-1:0] cand;
   logic                          valid_g;
   logic                          last_g;
   logic                          xfer;
   logic                          xfer_last;
   logic                          stall;

   function automatic int wrap_idx(input int v);
      if (v >= INPUT_NUMBER) begin
         return v - INPUT_NUMBER;
      end
      return v;
   endfunction

   // Search order starts one past the last-served port and wraps, so ptr_q itself is checked last.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = ptr_q;
      cand      = '0;
      for (int i = 1; i <= INPUT_NUMBER; i++) begin
         cand = INPUT_NUMBER_WIDTH'(wrap_idx(int'(ptr_q) + i));
         if (!sel_found && req_valid_i[cand] && req_header_i[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign valid_g   = req_valid_i[idx_q];
   assign last_g    = req_last_i[idx_q];
   assign xfer      = (state_q == ST_LOCKED) && valid_g && out_ready_i;
   assign xfer_last = xfer && last_g;
   assign stall     = (state_q == ST_LOCKED) && valid_g && !out_ready_i;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      vc_d    = vc_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (|(req_valid_i & ~req_header_i)) begin
               err_d = 1'b1;
            end
            if (sel_found) begin
               state_d = ST_LOCKED;
               idx_d   = sel_idx;
            end
         end
         ST_LOCKED: begin
            // Release always passes through IDLE, which gives the mandatory bubble cycle.
            if (xfer_last) begin
               state_d = ST_IDLE;
               ptr_d   = idx_q;
               vc_d    = ~vc_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);
         idx_q   <= '0;
         vc_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         vc_q    <= vc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      grant_o = '0;
      if (state_q == ST_LOCKED) begin
         grant_o[idx_q] = 1'b1;
      end
   end

   assign grant_idx_o   = idx_q;
   assign grant_valid_o = (state_q == ST_LOCKED);
   assign grant_vc_o    = vc_q;
   assign proto_err_o   = err_q;

`ifdef PACKET_ARBITER_PERF_EN
   logic [15:0] pkt_q;
   logic [15:0] stall_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pkt_q   <= '0;
         stall_q <= '0;
      end else begin
         if (xfer_last && (pkt_q != 16'hFFFF)) begin
            pkt_q <= pkt_q + 16'd1;
         end
         if (stall && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
      end
   end

   assign pkt_count_o   = pkt_q;
   assign stall_count_o = stall_q;
`else
   assign pkt_count_o   = 16'd0;
   assign stall_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_packet_arbiter_rr.sv
// Directed bench for packet_arbiter_rr with the default five input ports.
module tb_packet_arbiter_rr;

   localparam int N = 5;
   localparam int W = 3;
`ifdef PACKET_ARBITER_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic [N-1:0]  req_valid_i = '0;
   logic [N-1:0]  req_header_i = '0;
   logic [N-1:0]  req_last_i = '0;
   logic          out_ready_i = 1'b1;
   logic [N-1:0]  grant_o;
   logic [W-1:0]  grant_idx_o;
   logic          grant_valid_o;
   logic          grant_vc_o;
   logic          proto_err_o;
   logic [15:0]   pkt_count_o;
   logic [15:0]   stall_count_o;

   int total = 0;
   int bad   = 0;

   packet_arbiter_rr dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .req_valid_i   (req_valid_i),
      .req_header_i  (req_header_i),
      .req_last_i    (req_last_i),
      .out_ready_i   (out_ready_i),
      .grant_o       (grant_o),
      .grant_idx_o   (grant_idx_o),
      .grant_valid_o (grant_valid_o),
      .grant_vc_o    (grant_vc_o),
      .proto_err_o   (proto_err_o),
      .pkt_count_o   (pkt_count_o),
      .stall_count_o (stall_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      req_valid_i  = '0;
      req_header_i = '0;
      req_last_i   = '0;
      out_ready_i  = 1'b1;
      rst_n_i      = 1'b0;
      tick();
      tick();
      rst_n_i = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (grant_o !== 5'b00000) begin bad++; $display("FAIL reset_grant: got %b want 00000", grant_o); end
      total++; if (grant_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", grant_valid_o); end
      total++; if (grant_idx_o !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", grant_idx_o); end
      total++; if (grant_vc_o !== 1'b0) begin bad++; $display("FAIL reset_vc: got %b want 0", grant_vc_o); end
      total++; if (proto_err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", proto_err_o); end
      total++; if (pkt_count_o !== 16'd0 || stall_count_o !== 16'd0) begin
         bad++; $display("FAIL reset_counters: got pkt=%0d stall=%0d want 0 0", pkt_count_o, stall_count_o);
      end
   endtask

   task automatic test_two_ports();
      do_reset();
      req_valid_i  = 5'b01001;
      req_header_i = 5'b01001;
      tick();
      total++; if (grant_o !== 5'b00001) begin bad++; $display("FAIL two_first_grant: got %b want 00001", grant_o); end
      total++; if (grant_vc_o !== 1'b0) begin bad++; $display("FAIL two_first_vc: got %b want 0", grant_vc_o); end
      tick();
      req_header_i[0] = 1'b0;
      req_last_i[0]   = 1'b1;
      tick();
      req_valid_i[0] = 1'b0;
      req_last_i[0]  = 1'b0;
      total++; if (grant_valid_o !== 1'b0 || grant_o !== 5'b00000) begin
         bad++; $display("FAIL two_bubble: got valid=%b grant=%b want 0 00000", grant_valid_o, grant_o);
      end
      total++; if (grant_idx_o !== 3'd0) begin bad++; $display("FAIL two_idx_hold: got %0d want 0", grant_idx_o); end
      tick();
      total++; if (grant_o !== 5'b01000 || grant_idx_o !== 3'd3) begin
         bad++; $display("FAIL two_second_grant: got %b idx=%0d want 01000 idx=3", grant_o, grant_idx_o);
      end
      total++; if (grant_vc_o !== 1'b1) begin bad++; $display("FAIL two_second_vc: got %b want 1", grant_vc_o); end
      req_header_i[3] = 1'b0;
      req_last_i[3]   = 1'b1;
      tick();
      req_valid_i = '0;
      req_last_i  = '0;
      total++; if (grant_valid_o !== 1'b0) begin bad++; $display("FAIL two_release: got %b want 0", grant_valid_o); end
      total++; if (proto_err_o !== 1'b0) begin bad++; $display("FAIL two_no_err: got %b want 0", proto_err_o); end
      total++; if (pkt_count_o !== (PERF ? 16'd2 : 16'd0)) begin
         bad++; $display("FAIL two_pkt_count: got %0d want %0d", pkt_count_o, PERF ? 2 : 0);
      end
   endtask

   task automatic test_round_robin();
      int exp_order [6] = '{0, 1, 2, 3, 4, 0};
      logic [N-1:0] oh;
      do_reset();
      req_valid_i  = '1;
      req_header_i = '1;
      req_last_i   = '0;
      for (int k = 0; k < 6; k++) begin
         oh = '0;
         oh[exp_order[k]] = 1'b1;
         tick();
         total++; if (grant_idx_o !== W'(exp_order[k]) || grant_o !== oh) begin
            bad++; $display("FAIL rr_grant_%0d: got idx=%0d grant=%b want idx=%0d grant=%b", k, grant_idx_o, grant_o, exp_order[k], oh);
         end
         tick();
         req_header_i[exp_order[k]] = 1'b0;
         req_last_i[exp_order[k]]   = 1'b1;
         total++; if (grant_o !== oh) begin bad++; $display("FAIL rr_hold_%0d: got %b want %b", k, grant_o, oh); end
         tick();
         req_header_i[exp_order[k]] = 1'b1;
         req_last_i[exp_order[k]]   = 1'b0;
         if (k == 5) begin
            req_valid_i = '0;
         end
         total++; if (grant_valid_o !== 1'b0) begin bad++; $display("FAIL rr_bubble_%0d: got %b want 0", k, grant_valid_o); end
      end
      req_header_i = '0;
      total++; if (pkt_count_o !== (PERF ? 16'd6 : 16'd0)) begin
         bad++; $display("FAIL rr_pkt_count: got %0d want %0d", pkt_count_o, PERF ? 6 : 0);
      end
      total++; if (proto_err_o !== 1'b0) begin bad++; $display("FAIL rr_no_err: got %b want 0", proto_err_o); end
   endtask

   task automatic test_stall();
      do_reset();
      req_valid_i[2]  = 1'b1;
      req_header_i[2] = 1'b1;
      tick();
      out_ready_i = 1'b0;
      repeat (7) tick();
      total++; if (grant_o !== 5'b00100) begin bad++; $display("FAIL stall_hold: got %b want 00100", grant_o); end
      total++; if (stall_count_o !== (PERF ? 16'd7 : 16'd0)) begin
         bad++; $display("FAIL stall_count: got %0d want %0d", stall_count_o, PERF ? 7 : 0);
      end
      req_valid_i[2] = 1'b0;
      out_ready_i    = 1'b1;
      repeat (3) tick();
      total++; if (grant_o !== 5'b00100) begin bad++; $display("FAIL stall_idle_hold: got %b want 00100", grant_o); end
      total++; if (stall_count_o !== (PERF ? 16'd7 : 16'd0)) begin
         bad++; $display("FAIL stall_count_frozen: got %0d want %0d", stall_count_o, PERF ? 7 : 0);
      end
      req_valid_i[2]  = 1'b1;
      req_header_i[2] = 1'b0;
      req_last_i[2]   = 1'b1;
      tick();
      req_valid_i = '0;
      req_last_i  = '0;
      total++; if (grant_valid_o !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", grant_valid_o); end
   endtask

   task automatic test_proto_err();
      do_reset();
      req_valid_i[1] = 1'b1;
      tick();
      req_valid_i = '0;
      total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", proto_err_o); end
      total++; if (grant_valid_o !== 1'b0) begin bad++; $display("FAIL err_no_grant: got %b want 0", grant_valid_o); end
      repeat (3) tick();
      total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", proto_err_o); end
      // Single-beat packet on port 1: header and last together.
      req_valid_i[1]  = 1'b1;
      req_header_i[1] = 1'b1;
      req_last_i[1]   = 1'b1;
      tick();
      total++; if (grant_o !== 5'b00010) begin bad++; $display("FAIL single_grant: got %b want 00010", grant_o); end
      tick();
      req_valid_i  = '0;
      req_header_i = '0;
      req_last_i   = '0;
      total++; if (grant_valid_o !== 1'b0) begin bad++; $display("FAIL single_release: got %b want 0", grant_valid_o); end
      total++; if (grant_vc_o !== 1'b1) begin bad++; $display("FAIL single_vc: got %b want 1", grant_vc_o); end
      total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL err_still_set: got %b want 1", proto_err_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid_i[4]  = 1'b1;
      req_header_i[4] = 1'b1;
      tick();
      total++; if (grant_o !== 5'b10000) begin bad++; $display("FAIL mid_grant: got %b want 10000", grant_o); end
      tick();
      req_header_i[4] = 1'b0;
      #2;
      rst_n_i = 1'b0;
      #1;
      total++; if (grant_o !== 5'b00000 || grant_valid_o !== 1'b0) begin
         bad++; $display("FAIL mid_async_drop: got grant=%b valid=%b want 00000 0", grant_o, grant_valid_o);
      end
      req_valid_i  = 5'b10010;
      req_header_i = 5'b10010;
      tick();
      rst_n_i = 1'b1;
      tick();
      total++; if (grant_o !== 5'b00010 || grant_idx_o !== 3'd1) begin
         bad++; $display("FAIL mid_regrant: got %b idx=%0d want 00010 idx=1", grant_o, grant_idx_o);
      end
      total++; if (proto_err_o !== 1'b0 || grant_vc_o !== 1'b0) begin
         bad++; $display("FAIL mid_cleared: got err=%b vc=%b want 0 0", proto_err_o, grant_vc_o);
      end
      req_valid_i  = '0;
      req_header_i = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_two_ports();
      test_round_robin();
      test_stall();
      test_proto_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
